// File: rtl/mu0_control_if.sv
// MU0 control bus: opcode/flags/memory-ready into the sequencer, and the
// datapath enables, mux selects, ALU function, memory strobes and status out.
// master = control unit (mu0_control), slave = datapath/memory side.
interface mu0_control_if;
  logic [3:0] F;         // opcode, IR[15:12]
  logic       N;         // ACC negative
  logic       Z;         // ACC == 0
  logic       Mem_Rdy;   // memory completes the current Rd/Wr this cycle
  logic       IR_En;
  logic       PC_En;
  logic       Acc_En;
  logic       X_sel;     // 0=ACC, 1=PC
  logic       Y_sel;     // 0=memory data, 1=IR[11:0]
  logic       Addr_sel;  // 0=PC, 1=IR[11:0]
  logic [1:0] ALU_Fn;    // 00=Y, 01=X+Y, 10=X+1, 11=X-Y
  logic       Rd;
  logic       Wr;
  logic       Halted;
  logic       Fault;
  logic [1:0] State;

  modport master (
    input  F, N, Z, Mem_Rdy,
    output IR_En, PC_En, Acc_En, X_sel, Y_sel, Addr_sel, ALU_Fn,
           Rd, Wr, Halted, Fault, State
  );

  modport slave (
    output F, N, Z, Mem_Rdy,
    input  IR_En, PC_En, Acc_En, X_sel, Y_sel, Addr_sel, ALU_Fn,
           Rd, Wr, Halted, Fault, State
  );
endinterface

// File: rtl/mu0_control.sv
// MU0 fetch/execute sequencer with memory-ready handshake and bus-timeout watchdog.
// Ports: Clk, Reset (sync, active-high), bus (mu0_control_if.master).
// Outputs are combinational from state/F/N/Z/Mem_Rdy; stalls while Mem_Rdy=0, faults after MAX_WAIT.
module mu0_control #(
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic          Clk,
  input  logic          Reset,
  mu0_control_if.master bus
);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC  = 2'b01,
    HALT  = 2'b10,
    FAULT = 2'b11
  } state_t;

  localparam logic [WAIT_W-1:0] MAX_WAIT_W = WAIT_W'(MAX_WAIT);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic       ir_en, pc_en, acc_en;
  logic       x_sel, y_sel, addr_sel;
  logic [1:0] alu_fn;
  logic       rd, wr;

  always_comb begin
    ir_en    = 1'b0;
    pc_en    = 1'b0;
    acc_en   = 1'b0;
    x_sel    = 1'b0;
    y_sel    = 1'b0;
    addr_sel = 1'b0;
    alu_fn   = 2'b00;
    rd       = 1'b0;
    wr       = 1'b0;
    state_d  = state_q;
    wait_d   = '0;

    case (state_q)
      FETCH: begin
        // Read instruction at PC while the ALU forms PC+1.
        rd     = 1'b1;
        x_sel  = 1'b1;
        alu_fn = 2'b10;
        ir_en  = bus.Mem_Rdy;
        pc_en  = bus.Mem_Rdy;
        if (bus.Mem_Rdy) state_d = EXEC;
      end
      EXEC: begin
        case (bus.F)
          4'd0: begin  // LDA
            addr_sel = 1'b1;
            rd       = 1'b1;
            alu_fn   = 2'b00;
            acc_en   = bus.Mem_Rdy;
            if (bus.Mem_Rdy) state_d = FETCH;
          end
          4'd1: begin  // STA
            addr_sel = 1'b1;
            wr       = 1'b1;
            if (bus.Mem_Rdy) state_d = FETCH;
          end
          4'd2, 4'd3: begin  // ADD / SUB
            addr_sel = 1'b1;
            rd       = 1'b1;
            alu_fn   = (bus.F == 4'd2) ? 2'b01 : 2'b11;
            acc_en   = bus.Mem_Rdy;
            if (bus.Mem_Rdy) state_d = FETCH;
          end
          4'd4, 4'd5, 4'd6: begin  // JMP / JGE / JNE: PC <= IR[11:0]
            y_sel   = 1'b1;
            alu_fn  = 2'b00;
            pc_en   = (bus.F == 4'd4) | ((bus.F == 4'd5) & ~bus.N) |
                      ((bus.F == 4'd6) & ~bus.Z);
            state_d = FETCH;
          end
          4'd7:    state_d = HALT;
          default: state_d = FAULT;
        endcase
      end
      HALT:    state_d = HALT;
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase

    // Watchdog: a strobed access that is not ready holds the state; the
    // counter only survives while the state is unchanged, so any transition
    // leaves wait_d at its cleared default.
    if ((rd | wr) && !bus.Mem_Rdy) begin
      if (wait_q == MAX_WAIT_W) begin
        state_d = FAULT;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Reset abandons any access in flight: no enables or strobes that cycle.
  assign bus.IR_En    = ir_en  & ~Reset;
  assign bus.PC_En    = pc_en  & ~Reset;
  assign bus.Acc_En   = acc_en & ~Reset;
  assign bus.Rd       = rd     & ~Reset;
  assign bus.Wr       = wr     & ~Reset;
  assign bus.X_sel    = x_sel;
  assign bus.Y_sel    = y_sel;
  assign bus.Addr_sel = addr_sel;
  assign bus.ALU_Fn   = alu_fn;
  assign bus.Halted   = (state_q == HALT);
  assign bus.Fault    = (state_q == FAULT);
  assign bus.State    = state_q;

endmodule
